// File: rtl/pid_pkg.sv
// Shared types, constants and the saturating-sum helper for the PID front-end sequencer.
package pid_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ERR  = 3'd1,
    INT  = 3'd2,
    DIF  = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef struct packed {
    state_t state;
    logic   cout;
  } pid_dbg_t;

  // Overflow when both (already inverted) operands agree in sign but the sum does not.
  function automatic logic [DATA_W:0] sat_sum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] sum);
    logic ovf;
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    if (!ovf)
      return {1'b0, sum};
    else if (a[DATA_W-1])
      return {1'b1, SAT_NEG};
    else
      return {1'b1, SAT_POS};
  endfunction

endpackage

// File: rtl/pid_adder_sequencer_adder.sv
// Plain 16-bit ripple-carry adder shared by all three PID steps.
module adder_16bit
  import pid_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[DATA_W];

endmodule

// File: rtl/pid_adder_sequencer.sv
// Runs err, integral and derivative additions of one PID sample through a single shared adder.
module pid_adder_sequencer
  import pid_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] INT_MAX = 16'sd32767,
  parameter logic signed [DATA_W-1:0] INT_MIN = -16'sd32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] measurement,
  input  logic              int_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] err,
  output logic [DATA_W-1:0] integ,
  output logic [DATA_W-1:0] diff,
  output logic              sat,
  output pid_dbg_t          dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready/out_valid come from registered state only, and DONE holds results until taken.

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sp_q, meas_q, err_q, integ_q, diff_q, eprev_q;
  logic              sat_q;

  logic [DATA_W-1:0] op_a, op_b, sum;
  logic              cin, cout;
  logic [DATA_W:0]   sat_res;
  logic              ovf;
  logic [DATA_W-1:0] sat_val, int_val;
  logic              clamp;

  always_comb begin
    op_a = '0;
    op_b = '0;
    cin  = 1'b0;
    case (state)
      ERR: begin op_a = sp_q;    op_b = ~meas_q;  cin = 1'b1; end
      INT: begin op_a = integ_q; op_b = err_q;    cin = 1'b0; end
      DIF: begin op_a = err_q;   op_b = ~eprev_q; cin = 1'b1; end
      default: ;
    endcase
  end

  adder_16bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  assign sat_res = sat_sum(op_a, op_b, sum);
  assign ovf     = sat_res[DATA_W];
  assign sat_val = sat_res[DATA_W-1:0];

  always_comb begin
    int_val = sat_val;
    clamp   = 1'b0;
    if ($signed(sat_val) > INT_MAX) begin
      int_val = INT_MAX;
      clamp   = 1'b1;
    end else if ($signed(sat_val) < INT_MIN) begin
      int_val = INT_MIN;
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ERR;
      ERR:     state_nxt = INT;
      INT:     state_nxt = DIF;
      DIF:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      meas_q  <= '0;
      err_q   <= '0;
      integ_q <= '0;
      diff_q  <= '0;
      eprev_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Clear lands on the accept edge, so the INT/DIF steps of that sample see zero.
          if (int_clr) begin
            integ_q <= '0;
            eprev_q <= '0;
          end
          if (in_valid) begin
            sp_q   <= setpoint;
            meas_q <= measurement;
            sat_q  <= 1'b0;
          end
        end
        ERR: begin
          err_q <= sat_val;
          sat_q <= sat_q | ovf;
        end
        INT: begin
          integ_q <= int_val;
          sat_q   <= sat_q | ovf | clamp;
        end
        DIF: begin
          diff_q  <= sat_val;
          eprev_q <= err_q;
          sat_q   <= sat_q | ovf;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign err       = err_q;
  assign integ     = integ_q;
  assign diff      = diff_q;
  assign sat       = sat_q;
  assign dbg       = '{state: state, cout: cout};

endmodule

// File: tb/tb_pid_adder_sequencer.sv
// Bench for pid_adder_sequencer: a default-limit and a +/-1000-limit instance share stimulus.
module tb_pid_adder_sequencer;
  import pid_pkg::*;

  localparam int W = 49;  // {sat, diff, integ, err}

  logic        clk, rst_n;
  logic        in_valid, out_ready, int_clr;
  logic [15:0] setpoint, measurement;

  logic        in_ready_a, out_valid_a, sat_a;
  logic [15:0] err_a, integ_a, diff_a;
  pid_dbg_t    dbg_a;
  logic        in_ready_b, out_valid_b, sat_b;
  logic [15:0] err_b, integ_b, diff_b;
  pid_dbg_t    dbg_b;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  int tests_run, tests_failed;
  int m_integ_a, m_integ_b, m_eprev;

  pid_adder_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .setpoint(setpoint), .measurement(measurement), .int_clr(int_clr),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .err(err_a), .integ(integ_a), .diff(diff_a), .sat(sat_a), .dbg(dbg_a)
  );

  pid_adder_sequencer #(.INT_MAX(16'sd1000), .INT_MIN(-16'sd1000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .setpoint(setpoint), .measurement(measurement), .int_clr(int_clr),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .err(err_b), .integ(integ_b), .diff(diff_b), .sat(sat_b), .dbg(dbg_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: integer result, then saturate to 16-bit signed.
  function automatic int sat_int(input int v, input int hi, input int lo, output logic s);
    s = 1'b0;
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  function automatic logic [W-1:0] pack(input logic s, input int d, input int i, input int e);
    logic [15:0] d16, i16, e16;
    d16 = d[15:0];
    i16 = i[15:0];
    e16 = e[15:0];
    return {s, d16, i16, e16};
  endfunction

  // Driver: offer one sample in IDLE and push both expected results.
  task automatic accept(input logic [15:0] sp, input logic [15:0] ms, input logic clr);
    int n, e, ia, ib, d;
    logic s1, s2, s3, s4, s5;
    n = 0;
    while (!in_ready_a && n < 50) begin @(negedge clk); n++; end
    tests_run++;
    if (!in_ready_a) begin
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready_a);
      return;
    end
    setpoint = sp; measurement = ms; int_clr = clr; in_valid = 1'b1;
    if (clr) begin m_integ_a = 0; m_integ_b = 0; m_eprev = 0; end
    e  = sat_int(int'($signed(sp)) - int'($signed(ms)), 32767, -32768, s1);
    ia = sat_int(m_integ_a + e, 32767, -32768, s2);
    ib = sat_int(m_integ_b + e, 32767, -32768, s3);
    ib = sat_int(ib, 1000, -1000, s4);
    d  = sat_int(e - m_eprev, 32767, -32768, s5);
    m_integ_a = ia; m_integ_b = ib; m_eprev = e;
    exp_a_q.push_back(pack(s1 | s2 | s5, d, ia, e));
    exp_b_q.push_back(pack(s1 | s3 | s4 | s5, d, ib, e));
    @(negedge clk);
    in_valid = 1'b0; int_clr = 1'b0;
  endtask

  // Scoreboard: wait for out_valid, compare both instances, then complete the handshake.
  task automatic collect(output int lat);
    logic [W-1:0] ea, eb;
    lat = 0;
    while (!out_valid_a && lat < 50) begin @(negedge clk); lat++; end
    tests_run++;
    if (!out_valid_a || exp_a_q.size() == 0) begin
      tests_failed++;
      $display("FAIL out_valid_timeout: out_valid=%b queued=%0d required 1", out_valid_a, exp_a_q.size());
      return;
    end
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    tests_run++;
    if ({sat_a, diff_a, integ_a, err_a} !== ea) begin
      tests_failed++;
      $display("FAIL result_a: got sat=%b diff=%0d integ=%0d err=%0d required sat=%b diff=%0d integ=%0d err=%0d",
               sat_a, $signed(diff_a), $signed(integ_a), $signed(err_a),
               ea[48], $signed(ea[47:32]), $signed(ea[31:16]), $signed(ea[15:0]));
    end
    tests_run++;
    if (!out_valid_b || {sat_b, diff_b, integ_b, err_b} !== eb) begin
      tests_failed++;
      $display("FAIL result_b: got v=%b sat=%b diff=%0d integ=%0d err=%0d required sat=%b diff=%0d integ=%0d err=%0d",
               out_valid_b, sat_b, $signed(diff_b), $signed(integ_b), $signed(err_b),
               eb[48], $signed(eb[47:32]), $signed(eb[31:16]), $signed(eb[15:0]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL return_idle: out_valid=%b in_ready=%b required 0/1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; int_clr = 1'b0;
    setpoint = '0; measurement = '0;
    m_integ_a = 0; m_integ_b = 0; m_eprev = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({in_ready_a, out_valid_a, sat_a, err_a, integ_a, diff_a} !== {1'b1, 1'b0, 1'b0, 48'd0} ||
        {in_ready_b, out_valid_b, sat_b, err_b, integ_b, diff_b} !== {1'b1, 1'b0, 1'b0, 48'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sat=%b err=%h integ=%h diff=%h required 1 0 0 0 0 0",
               in_ready_a, out_valid_a, sat_a, err_a, integ_a, diff_a);
    end
  endtask

  task automatic test_basic();
    int lat;
    accept(16'd1000, 16'd400, 1'b0);
    collect(lat);
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL latency: got %0d edges after accept required 3", lat);
    end
    accept(16'd1000, 16'd900, 1'b0);
    collect(lat);
  endtask

  task automatic test_clamp();
    int lat;
    // err=600 on integ=700: instance b clamps at +1000
    accept(16'd1000, 16'd400, 1'b0);
    collect(lat);
    // large negative err: instance b clamps at -1000
    accept(-16'sd20000, 16'd0, 1'b0);
    collect(lat);
  endtask

  task automatic test_saturation();
    int lat;
    accept(16'd30000, -16'sd10000, 1'b0);
    collect(lat);
    accept(-16'sd30000, 16'd30000, 1'b0);
    collect(lat);
    accept(16'd0, 16'h8000, 1'b0);
    collect(lat);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] ea;
    accept(16'd123, -16'sd77, 1'b0);
    lat = 0;
    while (!out_valid_a && lat < 50) begin @(negedge clk); lat++; end
    ea = exp_a_q[0];
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      setpoint = 16'($urandom_range(0, 65535));
      measurement = 16'($urandom_range(0, 65535));
      @(negedge clk);
      tests_run++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || {sat_a, diff_a, integ_a, err_a} !== ea) begin
        tests_failed++;
        $display("FAIL backpressure_hold: cycle=%0d out_valid=%b in_ready=%b got %h required %h",
                 i, out_valid_a, in_ready_a, {sat_a, diff_a, integ_a, err_a}, ea);
      end
    end
    in_valid = 1'b0;
    collect(lat);
  endtask

  task automatic test_int_clr();
    int lat;
    accept(16'd50, 16'd0, 1'b1);
    collect(lat);
  endtask

  task automatic test_reset_mid();
    accept(16'd4000, 16'd1000, 1'b0);
    @(negedge clk);  // now in INT
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid_a, in_ready_a, sat_a, err_a, integ_a, diff_a} !== {1'b0, 1'b1, 1'b0, 48'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b sat=%b err=%h integ=%h diff=%h required 0 1 0 0 0 0",
               out_valid_a, in_ready_a, sat_a, err_a, integ_a, diff_a);
    end
    void'(exp_a_q.pop_back());
    void'(exp_b_q.pop_back());
    m_integ_a = 0; m_integ_b = 0; m_eprev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 20; i++) begin
      accept(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             ($urandom_range(0, 7) == 0));
      collect(lat);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_clamp();
    test_saturation();
    test_backpressure();
    test_int_clr();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (exp_a_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d results never produced, required 0", exp_a_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
